// File: rtl/uart_rx_fifo.sv
// UART receiver with a byte FIFO on the host side.
// Build option: define UART_RX_PARITY_EN for 8E1 framing. When it is undefined the frame is 8N1.
// The serial input is synchronised, and each bit is sampled in the middle of its bit period.
// Good bytes are pushed into the FIFO, and the host drains it with i_rd_en / o_rd_valid.
module uart_rx_fifo #(
    parameter int unsigned BAUD_CYCLES = 5,
    parameter int unsigned FIFO_DEPTH  = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_rxd,
    input  logic                         i_rd_en,
    output logic [7:0]                   o_rd_data,
    output logic                         o_rd_valid,
    output logic                         o_empty,
    output logic [$clog2(FIFO_DEPTH):0]  o_level,
    output logic                         o_frame_err,
    output logic                         o_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(BAUD_CYCLES);
    localparam logic [CW-1:0] SP_CNT   = CW'(BAUD_CYCLES / 2);
    localparam logic [CW-1:0] WRAP_CNT = CW'(BAUD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [LW-1:0] PTR_ONE  = LW'(1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          push_req;
    logic [7:0]    push_data;
    logic          frame_err;
`ifdef UART_RX_PARITY_EN
    logic          par_ok;
`endif

    logic rxd_meta, rxd_sync, rxd_dly;
    logic start_edge, at_sp, at_wrap;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [LW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop;

    // Two-flop synchroniser plus one delay stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_dly  <= 1'b1;
        end else begin
            rxd_meta <= i_rxd;
            rxd_sync <= rxd_meta;
            rxd_dly  <= rxd_sync;
        end
    end

    // Decode the start edge and the bit-period sample and wrap points.
    always_comb begin
        start_edge = rxd_dly & ~rxd_sync;
        at_sp      = (baud_cnt == SP_CNT);
        at_wrap    = (baud_cnt == WRAP_CNT);
    end

    // Receive FSM: frame the bits, then request a push or flag a framing error at the stop bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            push_req  <= 1'b0;
            push_data <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok    <= 1'b0;
`endif
        end else begin
            push_req  <= 1'b0;
            frame_err <= 1'b0;
            if (state != StIdle) begin
                baud_cnt <= at_wrap ? '0 : baud_cnt + CNT_ONE;
            end
            unique case (state)
                StIdle: begin
                    // A line that is already low never starts a frame. Only a falling edge does.
                    if (start_edge) begin
                        state    <= StStart;
                        baud_cnt <= '0;
                    end
                end
                StStart: begin
                    if (at_sp && rxd_sync) begin
                        state <= StIdle;
                    end else if (at_wrap) begin
                        state   <= StData;
                        bit_cnt <= '0;
                    end
                end
                StData: begin
                    if (at_sp) begin
                        shift <= {rxd_sync, shift[7:1]};
                    end
                    if (at_wrap) begin
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (at_sp) begin
                        par_ok <= ~(^{rxd_sync, shift});
                    end
                    if (at_wrap) begin
                        state <= StStop;
                    end
                end
`endif
                StStop: begin
                    // Leave at the sample point so that a back-to-back start edge is not missed.
                    if (at_sp) begin
                        state <= StIdle;
`ifdef UART_RX_PARITY_EN
                        if (!par_ok) begin
                            frame_err <= 1'b1;
                        end else
`endif
                        if (rxd_sync) begin
                            push_req  <= 1'b1;
                            push_data <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // FIFO status and the push/pop qualifiers. A pop in the same cycle never frees room for a push.
    always_comb begin
        empty      = (wr_ptr == rd_ptr);
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        push       = push_req & ~full;
        pop        = i_rd_en & ~empty;
        o_empty    = empty;
        o_level    = wr_ptr - rd_ptr;
        o_frame_err = frame_err;
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // FIFO pointers, pop data register and the overflow pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_rd_valid <= pop;
            o_overflow <= push_req & full;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                o_rd_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr    <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule
